// File: rtl/phase_seq_pkg.sv
// Shared phase indices, state encoding and sizing for the phase sequencer.
package phase_seq_pkg;

  localparam int unsigned PH_P = 0;
  localparam int unsigned PH_D = 1;
  localparam int unsigned PH_R = 2;
  localparam int unsigned PH_X = 3;
  localparam int unsigned PH_M = 4;
  localparam int unsigned PH_F = 5;
  localparam int unsigned PH_H = PH_F;

  localparam int unsigned NPHASE_DEF   = PH_H + 1;
  localparam int unsigned RETIRE_W_DEF = 32;
  localparam int unsigned REG_W        = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/phase_ring.sv
// One-hot phase ring: clear > force > load `p > hold > skip `f > rotate.
module phase_ring
  import phase_seq_pkg::*;
#(
  parameter int unsigned NPHASE = NPHASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_p,
  input  logic              hold,
  input  logic              skip_f,
  input  logic              force_en,
  input  logic [NPHASE-1:0] force_vec,
  output logic [NPHASE-1:0] phase
);

  logic [NPHASE-1:0] phase_d;
  logic [NPHASE-1:0] rot;

  always_comb begin
    rot     = {phase[NPHASE-2:0], phase[NPHASE-1]};
    phase_d = phase;
    if (clear) begin
      phase_d = '0;
    end else if (force_en) begin
      phase_d = force_vec;
    end else if (load_p) begin
      phase_d = NPHASE'(1) << PH_P;
    end else if (hold) begin
      phase_d = phase;
    end else if (skip_f && phase[PH_M]) begin
      phase_d = NPHASE'(1) << PH_P;
    end else begin
      phase_d = rot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else begin
      phase <= phase_d;
    end
  end

endmodule

// File: rtl/phase_seq.sv
// Phase sequencer for the miniCPU core plus debug arbitration of the register-file ports.
module phase_seq
  import phase_seq_pkg::*;
#(
  parameter int unsigned NPHASE   = NPHASE_DEF,
  parameter int unsigned RETIRE_W = RETIRE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mem_busy,
  input  logic                halt_req,
  input  logic                wb_en_dec,
  input  logic [REG_W-1:0]    dec_rg1,
  input  logic [REG_W-1:0]    dec_rg2,
  input  logic                dbg_req,
  input  logic                dbg_wr,
  input  logic [REG_W-1:0]    dbg_rg1,
  input  logic [REG_W-1:0]    dbg_rg2,
  output logic [NPHASE-1:0]   phase,
  output logic [REG_W-1:0]    rg1,
  output logic [REG_W-1:0]    rg2,
  output logic                regfile_sel,
  output logic                dbg_gnt,
  output logic                running,
  output logic [RETIRE_W-1:0] retired
);

  state_t              state_q, state_d;
  logic                halt_pend_q, halt_pend_d;
  logic                dbg_gnt_d, regfile_sel_d;
  logic [REG_W-1:0]    dbg_rg1_q, dbg_rg1_d;
  logic [REG_W-1:0]    dbg_rg2_q, dbg_rg2_d;
  logic                retire_inc;
  logic                ring_clear, ring_load_p, ring_hold, ring_skip_f, ring_force_en;
  logic [NPHASE-1:0]   ring_force_vec;
  logic                m_exit, f_exit;

  phase_ring #(.NPHASE(NPHASE)) u_ring (
    .clk       (clk),
    .rst       (rst),
    .clear     (ring_clear),
    .load_p    (ring_load_p),
    .hold      (ring_hold),
    .skip_f    (ring_skip_f),
    .force_en  (ring_force_en),
    .force_vec (ring_force_vec),
    .phase     (phase)
  );

  // Next state, ring control and debug arbitration.
  always_comb begin
    state_d        = state_q;
    halt_pend_d    = halt_pend_q;
    dbg_gnt_d      = 1'b0;
    regfile_sel_d  = 1'b0;
    dbg_rg1_d      = dbg_rg1_q;
    dbg_rg2_d      = dbg_rg2_q;
    retire_inc     = 1'b0;
    ring_clear     = 1'b0;
    ring_load_p    = 1'b0;
    ring_hold      = 1'b0;
    ring_skip_f    = 1'b0;
    ring_force_en  = 1'b0;
    ring_force_vec = '0;
    m_exit         = phase[PH_M] && !mem_busy;
    f_exit         = phase[PH_F];

    case (state_q)
      S_IDLE, S_HALT: begin
        // start wins over a simultaneous debug request
        if (start) begin
          state_d     = S_RUN;
          ring_load_p = 1'b1;
        end else if (dbg_req) begin
          dbg_gnt_d      = 1'b1;
          regfile_sel_d  = dbg_wr;
          dbg_rg1_d      = dbg_rg1;
          dbg_rg2_d      = dbg_rg2;
          ring_force_en  = 1'b1;
          ring_force_vec = dbg_wr ? (NPHASE'(1) << PH_F) : (NPHASE'(1) << PH_R);
        end else begin
          ring_clear = 1'b1;
        end
      end
      S_RUN: begin
        ring_hold   = mem_busy && (phase[PH_P] || phase[PH_M]);
        ring_skip_f = !wb_en_dec;
        if (phase[PH_X] && halt_req) begin
          halt_pend_d = 1'b1;
        end
        if ((m_exit && !wb_en_dec) || f_exit) begin
          retire_inc = 1'b1;
          if (halt_pend_q) begin
            state_d     = S_HALT;
            ring_clear  = 1'b1;
            halt_pend_d = 1'b0;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        ring_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      halt_pend_q <= 1'b0;
      dbg_gnt     <= 1'b0;
      regfile_sel <= 1'b0;
      dbg_rg1_q   <= '0;
      dbg_rg2_q   <= '0;
      running     <= 1'b0;
      retired     <= '0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      dbg_gnt     <= dbg_gnt_d;
      regfile_sel <= regfile_sel_d;
      dbg_rg1_q   <= dbg_rg1_d;
      dbg_rg2_q   <= dbg_rg2_d;
      running     <= (state_d == S_RUN);
      if (retire_inc) begin
        retired <= retired + RETIRE_W'(1);
      end
    end
  end

  // Decoded selects steer the regfile while running; debug selects otherwise.
  assign rg1 = (state_q == S_RUN) ? dec_rg1 : dbg_rg1_q;
  assign rg2 = (state_q == S_RUN) ? dec_rg2 : dbg_rg2_q;

endmodule
